// File: rtl/posit_mult_pipe.sv
// -----------------------------------------------------------------------------
// posit_mult_pipe
//   Four-stage pipelined posit<N,ES> multiplier with a valid/ready handshake,
//   a global stall enable and an opaque sideband tag that travels with each
//   operation.
//
//   Stage 1: special-case detect, absolute value, regime/exponent/fraction decode
//   Stage 2: hidden-bit mantissa multiply
//   Stage 3: normalise, combine scales, split into regime k and {e, fraction}
//   Stage 4: regime shift-in, saturation, optional rounding, sign, output regs
//
//   Optional feature macro: POSIT_MULT_ROUND_EN
//     defined   : round-to-nearest-even on the unsigned encoding in stage 4
//     undefined : truncation of bits shifted past the LSB
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready = global advance enable)
//   in_a, in_b, in_tag   posit operands and sideband tag
//   out_valid/out_ready  result handshake
//   out_result, out_tag  posit product and its tag
//   out_nar, out_zero    result is NaR / result is zero
// -----------------------------------------------------------------------------
module posit_mult_pipe #(
    parameter int N     = 16,
    parameter int ES    = 3,
    parameter int TAG_W = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nar,
    output logic             out_zero
);

    localparam int MW = N - ES + 1;             // hidden bit + fraction (+pad)
    localparam int PW = 2 * MW;                 // raw product width
    localparam int FW = PW - 1;                 // normalised fraction width
    localparam int LW = ES + FW;                // {exponent, fraction} field
    localparam int VW = LW + 2;                 // with two seed regime bits
    localparam int SW = ES + $clog2(N) + 3;     // signed scale width

    localparam logic [N-1:0]          NAR    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]          ZERO   = {N{1'b0}};
    localparam logic [N-2:0]          MAXPOS = {(N-1){1'b1}};
    localparam logic [N-2:0]          MINPOS = {{(N-2){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0]  K_MAX  = SW'(N - 2);
    localparam logic signed [SW-1:0]  K_MIN  = -K_MAX;

    // Length of the leading run of bits equal to the MSB.
    function automatic int run_len(input logic [N-2:0] r);
        int   cnt;
        logic done;
        cnt  = 0;
        done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!done && (r[i] == r[N-2])) begin
                cnt = cnt + 32'sd1;
            end else begin
                done = 1'b1;
            end
        end
        return cnt;
    endfunction

    // Decode a posit into {scale, mantissa}; scale = k*2^ES + e, mantissa is
    // 1.fraction left-aligned. Low bits of the negation depend only on the low
    // bits of the operand, so the sign bit never needs to be carried.
    function automatic logic [SW+MW-1:0] decode(input logic [N-1:0] p);
        logic [N-2:0] rem;
        logic [N-2:0] sh;
        logic [N-2:0] frac_al;
        logic [SW-1:0] k;
        logic [SW-1:0] e;
        logic [SW-1:0] scale;
        logic [MW-1:0] mant;
        int m;
        rem     = p[N-1] ? -p[N-2:0] : p[N-2:0];
        m       = run_len(rem);
        sh      = rem << (m + 32'sd1);          // drop regime and terminator
        k       = rem[N-2] ? SW'(m - 32'sd1) : SW'(-m);
        e       = SW'(sh >> (N - 1 - ES));
        frac_al = sh << ES;
        mant    = MW'({1'b1, frac_al, 1'b0} >> ES);
        scale   = (k << ES) + e;
        return {scale, mant};
    endfunction

    // ------------------------------------------------------------------ control
    logic adv_s;
    logic accept_s;

    assign adv_s    = out_ready | ~out_valid;
    assign accept_s = in_valid & adv_s;
    assign in_ready = adv_s;

    // ------------------------------------------------------------------ stage 1
    logic [SW+MW-1:0] dec_a_s;
    logic [SW+MW-1:0] dec_b_s;
    logic             nar_in_s;
    logic             zero_in_s;

    // Operand decode and special-case detection.
    always_comb begin
        dec_a_s   = decode(in_a);
        dec_b_s   = decode(in_b);
        nar_in_s  = (in_a == NAR) | (in_b == NAR);
        zero_in_s = (in_a == ZERO) | (in_b == ZERO);
    end

    logic             s1_valid_r, s1_nar_r, s1_zero_r, s1_sign_r;
    logic [SW-1:0]    s1_scale_a_r, s1_scale_b_r;
    logic [MW-1:0]    s1_mant_a_r, s1_mant_b_r;
    logic [TAG_W-1:0] s1_tag_r;

    // Stage 1 register: decoded operands, flags, sign and tag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_r   <= 1'b0;
            s1_nar_r     <= 1'b0;
            s1_zero_r    <= 1'b0;
            s1_sign_r    <= 1'b0;
            s1_scale_a_r <= {SW{1'b0}};
            s1_scale_b_r <= {SW{1'b0}};
            s1_mant_a_r  <= {MW{1'b0}};
            s1_mant_b_r  <= {MW{1'b0}};
            s1_tag_r     <= {TAG_W{1'b0}};
        end else if (adv_s) begin
            s1_valid_r   <= accept_s;
            s1_nar_r     <= nar_in_s;
            s1_zero_r    <= zero_in_s;
            s1_sign_r    <= in_a[N-1] ^ in_b[N-1];
            s1_scale_a_r <= dec_a_s[SW+MW-1:MW];
            s1_scale_b_r <= dec_b_s[SW+MW-1:MW];
            s1_mant_a_r  <= dec_a_s[MW-1:0];
            s1_mant_b_r  <= dec_b_s[MW-1:0];
            s1_tag_r     <= in_tag;
        end
    end

    // ------------------------------------------------------------------ stage 2
    logic             s2_valid_r, s2_nar_r, s2_zero_r, s2_sign_r;
    logic [SW-1:0]    s2_scale_r;
    logic [PW-1:0]    s2_prod_r;
    logic [TAG_W-1:0] s2_tag_r;

    // Stage 2 register: mantissa product and summed scale.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s2_valid_r <= 1'b0;
            s2_nar_r   <= 1'b0;
            s2_zero_r  <= 1'b0;
            s2_sign_r  <= 1'b0;
            s2_scale_r <= {SW{1'b0}};
            s2_prod_r  <= {PW{1'b0}};
            s2_tag_r   <= {TAG_W{1'b0}};
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r;
            s2_nar_r   <= s1_nar_r;
            s2_zero_r  <= s1_zero_r;
            s2_sign_r  <= s1_sign_r;
            s2_scale_r <= s1_scale_a_r + s1_scale_b_r;
            s2_prod_r  <= PW'(s1_mant_a_r) * PW'(s1_mant_b_r);
            s2_tag_r   <= s1_tag_r;
        end
    end

    // ------------------------------------------------------------------ stage 3
    logic                 ovf_s;
    logic [FW-1:0]        frac_s;
    logic signed [SW-1:0] scale_s;
    logic signed [SW-1:0] k_s;
    logic [LW-1:0]        lo_s;

    // Normalise the product into [1,2) and split the scale into k and e.
    always_comb begin
        ovf_s   = s2_prod_r[PW-1];
        frac_s  = ovf_s ? s2_prod_r[PW-2:0] : {s2_prod_r[PW-3:0], 1'b0};
        scale_s = s2_scale_r + {{(SW-1){1'b0}}, ovf_s};
        k_s     = scale_s >>> ES;
        lo_s    = LW'({scale_s, frac_s});   // low ES bits of scale are e
    end

    logic                 s3_valid_r, s3_nar_r, s3_zero_r, s3_sign_r;
    logic signed [SW-1:0] s3_k_r;
    logic [LW-1:0]        s3_lo_r;
    logic [TAG_W-1:0]     s3_tag_r;

    // Stage 3 register: regime value and {exponent, fraction} field.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s3_valid_r <= 1'b0;
            s3_nar_r   <= 1'b0;
            s3_zero_r  <= 1'b0;
            s3_sign_r  <= 1'b0;
            s3_k_r     <= {SW{1'b0}};
            s3_lo_r    <= {LW{1'b0}};
            s3_tag_r   <= {TAG_W{1'b0}};
        end else if (adv_s) begin
            s3_valid_r <= s2_valid_r;
            s3_nar_r   <= s2_nar_r;
            s3_zero_r  <= s2_zero_r;
            s3_sign_r  <= s2_sign_r;
            s3_k_r     <= k_s;
            s3_lo_r    <= lo_s;
            s3_tag_r   <= s2_tag_r;
        end
    end

    // ------------------------------------------------------------------ stage 4
    logic [VW-1:0] v_s;
    logic [SW-1:0] shamt_s;
    logic [VW-1:0] vs_s;
    logic [N-2:0]  trunc_s;
    logic [N-2:0]  enc_s;
    logic [N-1:0]  mag_s;
    logic [N-1:0]  res_s;
`ifdef POSIT_MULT_ROUND_EN
    logic          guard_s, round_s, sticky_s, up_s;
`endif

    // Regime shift-in: seed "10" (k>=0) or "01" (k<0) and arithmetic-shift so
    // the seed MSB replicates into the regime run; ~k equals -k-1.
    always_comb begin
        v_s     = s3_k_r[SW-1] ? {2'b01, s3_lo_r} : {2'b10, s3_lo_r};
        shamt_s = s3_k_r[SW-1] ? ~s3_k_r : s3_k_r;
        vs_s    = $signed(v_s) >>> shamt_s;
        trunc_s = (N-1)'(vs_s >> (VW - N + 1));
`ifdef POSIT_MULT_ROUND_EN
        guard_s  = vs_s[VW-N];
        round_s  = vs_s[VW-N-1];
        sticky_s = |vs_s[VW-N-2:0];
        up_s     = guard_s & (trunc_s[0] | round_s | sticky_s) & (trunc_s != MAXPOS);
`endif
        if (s3_k_r > K_MAX) begin
            enc_s = MAXPOS;
        end else if (s3_k_r < K_MIN) begin
            enc_s = MINPOS;
        end else begin
`ifdef POSIT_MULT_ROUND_EN
            enc_s = trunc_s + {{(N-2){1'b0}}, up_s};
`else
            enc_s = trunc_s;
`endif
        end
        mag_s = {1'b0, enc_s};
        if (s3_nar_r) begin
            res_s = NAR;
        end else if (s3_zero_r) begin
            res_s = ZERO;
        end else if (s3_sign_r) begin
            res_s = -mag_s;
        end else begin
            res_s = mag_s;
        end
    end

    logic             out_valid_r, out_nar_r, out_zero_r;
    logic [N-1:0]     out_result_r;
    logic [TAG_W-1:0] out_tag_r;

    // Output register: holds the result stable while downstream stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_r  <= 1'b0;
            out_nar_r    <= 1'b0;
            out_zero_r   <= 1'b0;
            out_result_r <= {N{1'b0}};
            out_tag_r    <= {TAG_W{1'b0}};
        end else if (adv_s) begin
            out_valid_r  <= s3_valid_r;
            out_nar_r    <= s3_nar_r;
            out_zero_r   <= s3_zero_r & ~s3_nar_r;
            out_result_r <= res_s;
            out_tag_r    <= s3_tag_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_nar    = out_nar_r;
    assign out_zero   = out_zero_r;
    assign out_result = out_result_r;
    assign out_tag    = out_tag_r;

endmodule

// File: doc/posit_mult_pipe.md
Name: posit_mult_pipe

Overview:
- Pipelined, fully parametrised posit multiplier (posit<N,es>). Successor to the single-cycle combinational posit multiplier.
- Adds a 4-stage registered datapath with valid/ready handshake and backpressure, and a sideband tag carried alongside each operation.
- Correct special-case handling: NaR priority, zero if either operand is zero, and saturation in place of under/overflow.
- Feeds the PairHMM stream datapath, where one product per cycle is required at full clock rate.

Parameters:
- N, 16, posit word width (8..32).
- ES, 3, exponent field width (0..4; ES <= N-3).
- TAG_W, 8, width of the opaque sideband tag carried with each operation.

Ports:
- aclk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- in_a  in  N  posit operand A.
- in_b  in  N  posit operand B.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  N  posit product.
- out_tag  out  TAG_W  tag of this result.
- out_nar  out  1  result is NaR.
- out_zero  out  1  result is zero.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; out_valid=0, out_result=0, out_tag=0, out_nar=0, out_zero=0. in_ready=1 immediately after reset.
- Pipeline stages:
  - S1: special-case detect, two's-complement of negative operands, regime/exponent/fraction decode.
  - S2: hidden-bit fraction multiply, (N-ES+1)x(N-ES+1) bits.
  - S3: normalise (product >= 2 shifts right by 1 and increments the scale); scale = 2^ES*(k_a+k_b) + e_a + e_b + ovf, signed, width ES+log2(N)+3; split scale into regime k and exponent e.
  - S4: regime shift-in (arithmetic right shift of {regime run, e, fraction}), conditional negate, register outputs.
- Latency: 4 cycles from input handshake to out_valid with out_ready held high. Throughput: 1 op/cycle.
- Handshake:
  - Global advance enable adv = out_ready | ~out_valid.
  - in_ready = adv (combinational).
  - When adv=0 every stage holds.
  - Input is accepted only when in_valid & in_ready; bubbles propagate as valid=0.
  - Stalled stages keep their data stable. out_result and out_tag must not change while out_valid & ~out_ready.
- Special cases, in priority order:
  - Either operand 1 followed by zeros (NaR) -> result NaR, out_nar=1.
  - Otherwise either operand 0 -> result 0, out_zero=1.
  - Otherwise the result is never 0 or NaR.
- Saturation:
  - |k| beyond the representable range clamps to maxpos (0 followed by ones) or minpos (0...01), with sign applied by two's complement.
- Sign: sA ^ sB. A negative result is the two's complement of the positive encoding.
- Rounding with the macro undefined: truncation. Bits shifted past the LSB are discarded.
- Reset asserted mid-stream: all in-flight ops are dropped, no output is produced for them, and outputs return to their reset values within the same cycle.
- Tag flows in lockstep with its operation and is never reordered.

Optional Feature:
- Macro: POSIT_MULT_ROUND_EN.
- Defined: S4 computes guard, round and sticky from the bits shifted out. It applies round-to-nearest-even on the unsigned encoding before negation. Rounding never produces 0 or NaR: it stays within minpos..maxpos. Latency is unchanged.
- Undefined: truncation, as described above; guard/round/sticky logic is absent.

Test Plan:
- N=16, ES=3, out_ready=1: A=0x4000 (1.0), B=0x4000 -> 0x4000 exactly 4 cycles later, out_nar=0, out_zero=0.
- A=0x4400 (2.0) x B=0x4400 -> 0x4800 (4.0). A=0x4000 x B=0xC000 (-1.0) -> 0xC000.
- A=0x8000 x B=0x0000 -> 0x8000, out_nar=1. A=0x0000 x B=0x4400 -> 0x0000, out_zero=1.
- Saturation: A=0x7FFF x B=0x7FFF -> 0x7FFF. A=0x0001 x B=0x0001 -> 0x0001. A=0x7FFF x B=0x8001 -> 0x8001.
- Backpressure: stream 8 ops with tags 0..7 and hold out_ready=0 for cycles 5..9. Expect in_ready=0 during the stall, outputs held stable, and all 8 results delivered in tag order with none lost or duplicated.
- Reset pulse (aresetn=0 for 1 cycle) with 3 ops in flight -> out_valid=0 immediately, and no results for those ops appear after release.
